// File: rtl/klingon_counter.sv
// klingon_counter: a single decimal digit (0..9) stepped up or down by two
// raw push-buttons. Each button is synchronized, then debounced by its own
// press/release FSM; an accepted press yields one step request.
// CARRY/BORROW pulse for one cycle on the 9->0 / 0->9 wraps.
module klingon_counter #(
  parameter int DB_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       CLR,
  output logic [3:0] NUM,
  output logic       CARRY,
  output logic       BORROW
);

  // The counter never needs to hold DB_CYCLES itself: the transition fires
  // while it holds DB_CYCLES-1 and the next sample agrees.
  localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } dbState_e;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0] btnRaw;
  logic [1:0] stepReq;

  assign btnRaw = {BTN_DOWN, BTN_UP};

  for (genvar b = 0; b < 2; b++) begin : gButton
    logic             syncMeta_q;
    logic             syncOut_q;
    dbState_e         state_q;
    dbState_e         state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             stepHit;

    // Two-flop synchronizer bringing the raw button into the CLK domain.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        syncMeta_q <= 1'b0;
        syncOut_q  <= 1'b0;
      end else begin
        syncMeta_q <= btnRaw[b];
        syncOut_q  <= syncMeta_q;
      end
    end

    // Debounce state and agreement counter; CLR deliberately has no effect here.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
      end
    end

    // Next state: a level must be seen DB_CYCLES samples in a row to be accepted.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
        IDLE: begin
          if (syncOut_q) begin
            state_d = PRESS_CHK;
            count_d = CNT_ONE;
          end
        end
        PRESS_CHK: begin
          if (!syncOut_q) begin
            state_d = IDLE;
            count_d = '0;
          end else if (count_q == CNT_LAST) begin
            state_d = HELD;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!syncOut_q) begin
            state_d = REL_CHK;
            count_d = CNT_ONE;
          end
        end
        REL_CHK: begin
          if (syncOut_q) begin
            state_d = HELD;
            count_d = '0;
          end else if (count_q == CNT_LAST) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    // Step request fires on the single PRESS_CHK->HELD transition, so holding gives no repeat.
    always_comb begin
      stepHit = (state_q == PRESS_CHK) && syncOut_q && (count_q == CNT_LAST);
    end

    assign stepReq[b] = stepHit;
  end

  logic       upReq;
  logic       downReq;
  logic [3:0] num_q;
  logic [3:0] num_d;
  logic       carry_q;
  logic       carry_d;
  logic       borrow_q;
  logic       borrow_d;

  assign upReq   = stepReq[0];
  assign downReq = stepReq[1];

  // Digit update: CLR wins over requests, and opposing requests cancel.
  always_comb begin
    num_d    = num_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (CLR) begin
      num_d = 4'd0;
    end else if (upReq && !downReq) begin
      if (num_q >= 4'd9) begin
        num_d   = 4'd0;
        carry_d = 1'b1;
      end else begin
        num_d = num_q + 4'd1;
      end
    end else if (downReq && !upReq) begin
      if (num_q == 4'd0) begin
        num_d    = 4'd9;
        borrow_d = 1'b1;
      end else if (num_q > 4'd9) begin
        num_d = 4'd9;
      end else begin
        num_d = num_q - 4'd1;
      end
    end
  end

  // Registered digit and wrap pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      num_q    <= 4'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      num_q    <= num_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign NUM    = num_q;
  assign CARRY  = carry_q;
  assign BORROW = borrow_q;

  numInRange: assert property (@(posedge CLK) disable iff (!RST_N) num_q <= 4'd9);
  wrapExclusive: assert property (@(posedge CLK) disable iff (!RST_N) !(carry_q && borrow_q));
  carrySingle: assert property (@(posedge CLK) disable iff (!RST_N) carry_q |=> !carry_q);
  borrowSingle: assert property (@(posedge CLK) disable iff (!RST_N) borrow_q |=> !borrow_q);

endmodule

// File: tb/tb_klingon_counter.sv
// Testbench for klingon_counter: every NUM/CARRY/BORROW change is matched
// against a queue of expected events (edge number, digit, pulses).
module tb_klingon_counter;

  localparam int DB = 4;

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b1;
  logic       BTN_UP   = 1'b0;
  logic       BTN_DOWN = 1'b0;
  logic       CLR      = 1'b0;
  logic [3:0] NUM;
  logic       CARRY;
  logic       BORROW;

  typedef struct {
    int         cycle;
    logic [3:0] num;
    logic       carry;
    logic       borrow;
  } expEvent_t;

  expEvent_t sbQ[$];
  expEvent_t monEv;

  int         vectorCount = 0;
  int         missCount   = 0;
  int         cycle       = 0;
  int         driveCycle  = 0;
  int         modelNum    = 0;
  logic [3:0] prevNum     = 4'd0;
  logic       bouncePat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  klingon_counter #(.DB_CYCLES(DB)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BTN_UP  (BTN_UP),
    .BTN_DOWN(BTN_DOWN),
    .CLR     (CLR),
    .NUM     (NUM),
    .CARRY   (CARRY),
    .BORROW  (BORROW)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  // Rising-edge counter so expected events can name the exact edge.
  always @(posedge CLK) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Levels change at a falling edge and hold until the next call.
  task automatic applyStimulus(input logic up, input logic down, input logic clr);
    @(negedge CLK);
    BTN_UP     = up;
    BTN_DOWN   = down;
    CLR        = clr;
    driveCycle = cycle;
  endtask

  task automatic holdCycles(input int n);
    repeat (n - 1) @(negedge CLK);
  endtask

  function automatic void expectStep(input int dir, input int at);
    expEvent_t e;
    e.cycle  = at;
    e.carry  = 1'b0;
    e.borrow = 1'b0;
    if (dir > 0) begin
      if (modelNum == 9) begin
        modelNum = 0;
        e.carry  = 1'b1;
      end else begin
        modelNum++;
      end
    end else begin
      if (modelNum == 0) begin
        modelNum = 9;
        e.borrow = 1'b1;
      end else begin
        modelNum--;
      end
    end
    e.num = 4'(modelNum);
    sbQ.push_back(e);
  endfunction

  function automatic void expectClear(input int at);
    expEvent_t e;
    if (modelNum != 0) begin
      e.cycle  = at;
      e.num    = 4'd0;
      e.carry  = 1'b0;
      e.borrow = 1'b0;
      sbQ.push_back(e);
    end
    modelNum = 0;
  endfunction

  // Clean press: held holdN edges, then released long enough to settle.
  task automatic pressButton(input logic up, input logic down, input int holdN);
    applyStimulus(up, down, 1'b0);
    if (up && !down) expectStep(1, driveCycle + DB + 2);
    else if (down && !up) expectStep(-1, driveCycle + DB + 2);
    holdCycles(holdN);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "-pending"}, 32'(sbQ.size()), 32'd0);
    checkOutput({tag, "-num"}, 32'(NUM), 32'(modelNum));
  endtask

  // Monitor: any digit change or pulse must match the oldest expected event.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prevNum = NUM;
    end else if (NUM !== prevNum || CARRY !== 1'b0 || BORROW !== 1'b0) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedEvent", 32'({NUM, CARRY, BORROW}), 32'({prevNum, 2'b00}));
      end else begin
        monEv = sbQ.pop_front();
        checkOutput("eventEdge", 32'(cycle), 32'(monEv.cycle));
        checkOutput("num", 32'(NUM), 32'(monEv.num));
        checkOutput("carry", 32'(CARRY), 32'(monEv.carry));
        checkOutput("borrow", 32'(BORROW), 32'(monEv.borrow));
      end
      prevNum = NUM;
    end
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, %0d events pending", sbQ.size());
    $fatal(1, "[TB] timeout");
  end

  initial begin
    $display("[TB] klingon_counter bench, DB_CYCLES=%0d", DB);
    #1 RST_N = 1'b0;
    #2;
    checkOutput("resetNum", 32'(NUM), 32'd0);
    checkOutput("resetCarry", 32'(CARRY), 32'd0);
    checkOutput("resetBorrow", 32'(BORROW), 32'd0);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;

    // Long hold gives exactly one step at edge DB+2.
    pressButton(1'b1, 1'b0, 10);
    checkIdle("holdOnce");

    // Clear back to zero, then ten presses with a carry on the wrap.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectClear(driveCycle + 1);
    holdCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(2);
    for (int i = 0; i < 10; i++) pressButton(1'b1, 1'b0, 8);
    checkIdle("upWrap");

    // Down from zero borrows, the next one does not.
    pressButton(1'b0, 1'b1, 8);
    pressButton(1'b0, 1'b1, 8);
    checkIdle("downWrap");

    // Short glitch produces nothing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
    checkIdle("glitch");

    // One press followed by a bouncing release gives a single step.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectStep(1, driveCycle + DB + 2);
    holdCycles(10);
    for (int i = 0; i < 7; i++) applyStimulus(bouncePat[i], 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
    checkIdle("bounce");

    // Both buttons together cancel.
    pressButton(1'b1, 1'b1, 10);
    checkIdle("cancel");

    // CLR on the very edge of an up request at 9: zero, no carry.
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    expectClear(driveCycle + 1);
    holdCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
    checkIdle("clrOnStep");

    // CLR early in a press leaves the debouncer alone.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectStep(1, driveCycle + DB + 2);
    holdCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    holdCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdCycles(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
    checkIdle("clrMidPress");

    // Walk up to 7, then pulse reset between edges.
    for (int i = 0; i < 6; i++) pressButton(1'b1, 1'b0, 8);
    checkIdle("reachSeven");
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("rstPulseNum", 32'(NUM), 32'd0);
    checkOutput("rstPulseCarry", 32'(CARRY), 32'd0);
    checkOutput("rstPulseBorrow", 32'(BORROW), 32'd0);
    modelNum = 0;
    @(negedge CLK);
    #2 RST_N = 1'b1;

    // Reset in the middle of a press that stays held: one fresh step afterwards.
    applyStimulus(1'b1, 1'b0, 1'b0);
    holdCycles(3);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    expectStep(1, cycle + DB + 2);
    repeat (DB + 8) @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 1'b0);
    holdCycles(12);
    checkIdle("rstMidPress");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
